// File: rtl/kamikaze_pkg.sv
// Shared constants and types for the kamikaze core.
package kamikaze_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG_MAX = 32;

  typedef logic [$clog2(NREG_MAX)-1:0] regaddr_t;

  localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/kamikaze_regfile_rdport.sv
// One register-file read port: x0 forcing, same-cycle write bypass and an
// enable-gated output register that holds while the port is idle.
module kamikaze_regfile_rdport #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rf_data_i,
  output logic [XLEN-1:0] rdata_o
);
  import kamikaze_pkg::*;

  logic [XLEN-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (raddr_i == AW'(REG_ZERO)) begin
        rdata_d = '0;
      end else if (we_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = rf_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kamikaze_regfile_sb.sv
// Integer register file with NRD registered read ports, one write port,
// write-to-read bypass, hardwired x0 and a pending-write scoreboard.
module kamikaze_regfile_sb #(
  parameter int unsigned XLEN = kamikaze_pkg::XLEN,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [NRD-1:0]      re_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      busy_o,
  input  logic                issue_i,
  input  logic [AW-1:0]       issue_addr_i,
  input  logic                flush_i
);
  import kamikaze_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pending_d, pending_q;
  logic            wr_valid;
  logic            issue_valid;
  logic [AW-1:0]   raddr [NRD];

  assign wr_valid    = we_i && (waddr_i != AW'(REG_ZERO));
  assign issue_valid = issue_i && (issue_addr_i != AW'(REG_ZERO));

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Clear before set: a same-cycle issue to the written register belongs to a
  // newer instruction whose write is still outstanding.
  always_comb begin
    pending_d = pending_q;
    if (wr_valid) begin
      pending_d[waddr_i] = 1'b0;
    end
    if (flush_i) begin
      pending_d = '0;
    end else if (issue_valid) begin
      pending_d[issue_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rdport
    assign raddr[k] = raddr_i[k*AW +: AW];

    // A write landing this cycle is bypassed, so the operand is not busy.
    assign busy_o[k] = pending_q[raddr[k]] & ~(we_i & (waddr_i == raddr[k]));

    kamikaze_regfile_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .re_i     (re_i[k]),
      .raddr_i  (raddr[k]),
      .we_i     (we_i),
      .waddr_i  (waddr_i),
      .wdata_i  (wdata_i),
      .rf_data_i(regs_q[raddr[k]]),
      .rdata_o  (rdata_o[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_kamikaze_regfile_sb.sv
// Directed plus random checks of kamikaze_regfile_sb against a behavioural model.
module tb_kamikaze_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  busy;
  logic        issue;
  logic [4:0]  iaddr;
  logic        flush;

  logic        b_we;
  logic [3:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [2:0]  b_re;
  logic [11:0] b_raddr;
  logic [95:0] b_rdata;
  logic [2:0]  b_busy;
  logic        b_issue;
  logic [3:0]  b_iaddr;
  logic        b_flush;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [32];
  bit          pend [32];
  logic [31:0] exp_rd [2];
  logic [1:0]  busy_obs;

  kamikaze_regfile_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .busy_o(busy),
    .issue_i(issue), .issue_addr_i(iaddr), .flush_i(flush)
  );

  kamikaze_regfile_sb #(.XLEN(32), .NREG(16), .NRD(3)) dut_e (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .re_i(b_re), .raddr_i(b_raddr), .rdata_o(b_rdata), .busy_o(b_busy),
    .issue_i(b_issue), .issue_addr_i(b_iaddr), .flush_i(b_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    issue = 1'b0; iaddr = '0; flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      pend[i] = 1'b0;
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One clock: check busy mid-cycle, advance the model, check read data after the edge.
  task automatic cycle();
    logic [4:0] a;
    bit         eb;
    @(negedge clk);
    busy_obs = busy;
    for (int k = 0; k < 2; k++) begin
      a  = raddr[k*5 +: 5];
      eb = (a != 0) && pend[a] && !(we && waddr == a);
      chk($sformatf("busy%0d", k), {31'b0, busy[k]}, {31'b0, eb});
      if (re[k]) begin
        if (a == 0) exp_rd[k] = '0;
        else if (we && waddr == a) exp_rd[k] = wdata;
        else exp_rd[k] = mem[a];
      end
    end
    if (we && waddr != 0) begin
      mem[waddr] = wdata;
      pend[waddr] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    end else if (issue && iaddr != 0) begin
      pend[iaddr] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rdata%0d", k), rdata[k*32 +: 32], exp_rd[k]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_re = '0; b_raddr = '0;
    b_issue = 1'b0; b_iaddr = '0; b_flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd0", rdata[31:0], 32'h0);
    chk("reset_rd1", rdata[63:32], 32'h0);
    chk("reset_busy", {30'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // x0 hardwiring
    clr(); we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; cycle();
    clr(); re = 2'b11; raddr = {5'd0, 5'd0}; cycle();
    chk("x0_rd0", rdata[31:0], 32'h0);
    chk("x0_rd1", rdata[63:32], 32'h0);
    clr(); issue = 1'b1; iaddr = 5'd0; cycle();
    clr(); cycle();
    chk("x0_busy", {30'b0, busy_obs}, 32'h0);

    // same-cycle bypass on port 0, stored value on port 1
    clr(); we = 1'b1; waddr = 5'd6; wdata = 32'hA5A5A5A5; cycle();
    clr(); we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    re = 2'b11; raddr = {5'd6, 5'd5}; cycle();
    chk("bypass_p0", rdata[31:0], 32'h12345678);
    chk("bypass_p1", rdata[63:32], 32'hA5A5A5A5);

    // hold while re is low
    clr(); we = 1'b1; waddr = 5'd7; wdata = 32'h1; cycle();
    clr(); re = 2'b01; raddr = {5'd0, 5'd7}; cycle();
    chk("hold_read", rdata[31:0], 32'h1);
    clr(); we = 1'b1; waddr = 5'd7; wdata = 32'h2; raddr = {5'd0, 5'd7}; cycle();
    chk("hold_wr", rdata[31:0], 32'h1);
    clr(); raddr = {5'd0, 5'd7}; cycle();
    chk("hold_idle", rdata[31:0], 32'h1);
    clr(); re = 2'b01; raddr = {5'd0, 5'd7}; cycle();
    chk("hold_reread", rdata[31:0], 32'h2);

    // scoreboard
    clr(); issue = 1'b1; iaddr = 5'd3; raddr = {5'd0, 5'd3}; cycle();
    clr(); raddr = {5'd0, 5'd3}; cycle();
    chk("sb_issue", {31'b0, busy_obs[0]}, 32'h1);
    clr(); we = 1'b1; waddr = 5'd3; wdata = 32'h77; raddr = {5'd0, 5'd3}; cycle();
    chk("sb_wr_bypass", {31'b0, busy_obs[0]}, 32'h0);
    clr(); issue = 1'b1; iaddr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h88; cycle();
    clr(); raddr = {5'd0, 5'd3}; cycle();
    chk("sb_set_wins", {31'b0, busy_obs[0]}, 32'h1);

    // flush beats a same-cycle issue
    clr(); issue = 1'b1; iaddr = 5'd4; cycle();
    clr(); issue = 1'b1; iaddr = 5'd9; cycle();
    clr(); issue = 1'b1; iaddr = 5'd12; raddr = {5'd9, 5'd4}; cycle();
    chk("flush_pre", {30'b0, busy_obs}, 32'h3);
    clr(); flush = 1'b1; issue = 1'b1; iaddr = 5'd4; raddr = {5'd9, 5'd4}; cycle();
    chk("flush_nocomb", {30'b0, busy_obs}, 32'h3);
    clr(); raddr = {5'd9, 5'd4}; cycle();
    chk("flush_4_9", {30'b0, busy_obs}, 32'h0);
    clr(); raddr = {5'd0, 5'd12}; cycle();
    chk("flush_12", {30'b0, busy_obs}, 32'h0);

    // randomized traffic on a narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      re    = 2'($urandom_range(0, 3));
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      issue = 1'($urandom_range(0, 1));
      iaddr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // reset mid-run with pending bits and stored data present
    clr(); issue = 1'b1; iaddr = 5'd2; we = 1'b1; waddr = 5'd1; wdata = 32'hCAFE0001;
    re = 2'b11; raddr = {5'd1, 5'd6}; cycle();
    clr();
    rst_n = 1'b0;
    #2;
    chk("rst_async0", rdata[31:0], 32'h0);
    chk("rst_async1", rdata[63:32], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 1; i < 32; i++) begin
      clr(); re = 2'b11; raddr = {5'(32 - i), 5'(i)}; cycle();
    end

    // RV32E, three ports: flush and shared-address reads
    @(negedge clk);
    b_issue = 1'b1; b_iaddr = 4'd4;  @(negedge clk);
    b_iaddr = 4'd9;  @(negedge clk);
    b_iaddr = 4'd12; @(negedge clk);
    b_issue = 1'b0; b_raddr = {4'd12, 4'd9, 4'd4};
    #1;
    chk("e_pre", {29'b0, b_busy}, 32'h7);
    b_flush = 1'b1; b_issue = 1'b1; b_iaddr = 4'd4;
    #1;
    chk("e_nocomb", {29'b0, b_busy}, 32'h7);
    @(negedge clk);
    b_flush = 1'b0; b_issue = 1'b0;
    #1;
    chk("e_flush", {29'b0, b_busy}, 32'h0);
    b_we = 1'b1; b_waddr = 4'd15; b_wdata = 32'h5A5A0F0F;
    b_re = 3'b111; b_raddr = {4'd15, 4'd15, 4'd15};
    @(negedge clk);
    b_we = 1'b0; b_re = 3'b000;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("e_same%0d", k), b_rdata[k*32 +: 32], 32'h5A5A0F0F);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kamikaze_regfile_sb.md
# kamikaze_regfile_sb

Parametrised integer register file for the kamikaze core, with N synchronous read ports, one write port, write-to-read bypass, hardwired-zero register 0, and a per-register pending-write scoreboard. Decode uses it for operand fetch and RAW-hazard detection. Writeback drives the write port. It replaces the fixed 2R1W, 32x32 register file.

## Interface
- `XLEN`, default 32: register width in bits.
- `NREG`, default 32: register count; legal values are 16 (RV32E) and 32. `AW = $clog2(NREG)`.
- `NRD`, default 2: number of read ports, 1..4.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `we_i`  in  1  write enable.
- `waddr_i`  in  AW  write address.
- `wdata_i`  in  XLEN  write data.
- `re_i`  in  NRD  per-port read enable; when low, the port holds its output.
- `raddr_i`  in  NRD*AW  read addresses, port k in bits [k*AW +: AW].
- `rdata_o`  out  NRD*XLEN  registered read data, port k in bits [k*XLEN +: XLEN].
- `busy_o`  out  NRD  combinational: the register at `raddr_i[k]` has a write outstanding.
- `issue_i`  in  1  an instruction with a destination register issues this cycle.
- `issue_addr_i`  in  AW  destination of the issuing instruction.
- `flush_i`  in  1  clears all pending bits (pipeline flush).

## Operation
- **Storage:** NREG x XLEN flops. Register 0 always reads 0. Writes to address 0 are dropped.
- **Write:** on a rising edge with `we_i`=1 and `waddr_i`≠0, the register at `waddr_i` takes `wdata_i`.
- **Read, port k, when `re_i[k]`=1:** `rdata_o[k]` is loaded with:
  - 0 if `raddr_i[k]`=0;
  - otherwise `wdata_i` if `we_i` is high and `waddr_i` equals `raddr_i[k]` (same-cycle bypass);
  - otherwise the stored value.
- **Read, port k, when `re_i[k]`=0:** `rdata_o[k]` holds its previous value, including across writes to the same address.
- **Scoreboard:** one pending bit per register; bit 0 is constant 0.
  - `issue_i` with `issue_addr_i`≠0 sets pending[`issue_addr_i`].
  - `we_i` with `waddr_i`≠0 clears pending[`waddr_i`].
  - Set and clear on the same address in the same cycle: set wins, because the newer instruction's write is still outstanding.
  - `flush_i` clears every pending bit. It takes priority over `issue_i` in that cycle; `we_i` still writes data.
- **`busy_o[k]`** = pending[`raddr_i[k]`] AND NOT (`we_i` AND `waddr_i`==`raddr_i[k]`). A write landing this cycle is bypassed, so it does not count as busy. `busy_o[k]` is 0 for address 0.
- **Reset:** the asynchronous assert clears all registers, all pending bits and all `rdata_o` to 0. Deassertion is used synchronously by the parent.

## Timing
- Read latency: 1 cycle. Address at edge n gives data on `rdata_o` after edge n+1.
- Write to read (different cycle): a write at edge n is visible to a read sampled at edge n+1 or later.
- Same-cycle write and read of the same address: the new data appears with the 1-cycle read latency.
- `busy_o` is combinational from `raddr_i`, `we_i`, `waddr_i` and pending state. There is no path from `issue_i` or `flush_i`: they affect `busy_o` from the next cycle.
- Reset mid-operation: an in-flight read returns 0 and the pending state is lost. The parent flushes the pipeline on reset.
- Several read ports may use the same address in one cycle; each returns identical data.

## Structure
- Shared package `kamikaze_pkg` holds:
  - `XLEN`;
  - `REG_ZERO` (address 0);
  - the `regaddr_t` typedef sized for NREG=32.
- Sub-module `kamikaze_regfile_rdport`: one read port containing the zero check, bypass mux and hold register with enable. It is instantiated NRD times in a generate loop.
- The scoreboard and storage stay in the top module.

## Test plan
- **Reset:** assert `rst_n_i`=0 mid-run, release, then read x1..x31 on all ports → all `rdata_o` are 0 and `busy_o`=0.
- **x0 hardwiring:** write 0xDEADBEEF to x0, then read x0 → 0; issue to x0 → `busy_o`=0 for x0.
- **Bypass:** in one cycle, write x5=0x12345678 and read x5 on port 0 with x6 (previously 0xA5A5A5A5) on port 1 → next cycle port 0 = 0x12345678, port 1 = 0xA5A5A5A5.
- **Hold:** read x7=0x1 with `re_i`=1, then drop `re_i` and write x7=0x2 → `rdata_o` stays 0x1 until `re_i` rises again, then reads 0x2.
- **Scoreboard:**
  - issue x3, then read x3 → `busy_o`=1;
  - write x3 while raddr=x3 → `busy_o`=0 that cycle;
  - issue x3 and write x3 in the same cycle → `busy_o`=1 the next cycle.
- **Flush:** issue x4, x9 and x12, then assert `flush_i` together with an issue to x4 → the next cycle `busy_o`=0 for all three; repeat with NREG=16, NRD=3.
